rsa_modexp_engine: RTL and testbench
====================================

# rsa_modexp_engine

Bit-serial RSA modular-exponentiation engine computing result = msg^key mod n. Sits directly downstream of the RSA mode decoder: it consumes the decoder's 2-bit E_D select (10 = encrypt, 01 = decrypt) and picks the public exponent e or the private exponent d. It uses square-and-multiply over an interleaved shift-add modular multiplier, with a start/done handshake to the host controller.

## Interface
- WIDTH, 16, operand width of msg, e, d, n and result
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge
- E_D  in  2  mode select from decoder; 10 = encrypt (use key_e), 01 = decrypt (use key_d), others invalid
- start  in  1  request pulse; accepted only when busy=0
- msg_in  in  WIDTH  message or ciphertext; must be < modulus_n
- key_e  in  WIDTH  public exponent
- key_d  in  WIDTH  private exponent
- modulus_n  in  WIDTH  modulus; must be >= 2
- busy  out  1  high from the accepting edge until done
- done  out  1  single-cycle completion pulse
- err  out  1  invalid request flag; held until the next accepted start
- result  out  WIDTH  exponentiation result; held until the next accepted start

## Operation
- Reset (rst_n=0 at an edge): state IDLE; busy, done and err = 0; result = 0; internal registers cleared. Reset mid-operation aborts the operation and produces no done.
- IDLE: on start=1, capture E_D, msg_in, the selected key and modulus_n; clear err.
  - Invalid request (E_D in {00,11}, modulus_n < 2, or msg_in >= modulus_n): go to FIN with err=1 and result=0.
  - Valid request: base=msg_in, exp=key, acc=1; go to EVAL.
- EVAL (1 cycle): exp==0 -> FIN; exp[0]==1 -> MUL; else -> SQR.
- MUL (WIDTH cycles): acc = acc*base mod n. Then, if exp>>1 == 0, shift exp and go to FIN; else go to SQR.
- SQR (WIDTH cycles): base = base*base mod n; exp = exp>>1; go to EVAL.
- FIN (1 cycle): result = acc (or 0 on err); done=1; busy=0 on the next edge; return to IDLE.
- Modular multiplier: MSB-first interleaved, one multiplier bit per cycle: p = 2p, reduce; if b[i], p = p + a, reduce. Reduction is conditional subtraction of n, up to twice per cycle. Internal width WIDTH+2, so no overflow for n up to 2^WIDTH-1. Operands stay < n throughout.
- start while busy=1 is ignored. E_D, key and msg changes after the accepting edge are ignored.
- Key of 0: result=1 with err=0.

## Timing
- Start sampled high at edge k: busy=1 from edge k.
- Default build: FIN entered at edge k + L, where L = bitlen(exp) + WIDTH*(popcount(exp) + bitlen(exp) - 1). done is high for exactly one cycle, from edge k+L to edge k+L+1. result is valid from edge k+L onward.
- Invalid request or exp==0: FIN at edge k+1.
- busy falls at edge k+L+1. A new start is accepted at edge k+L+1 at the earliest.
- No back-pressure. done is not held.

## Configuration
- RSA_CONST_TIME_EN defined: constant-time mode.
  - Every request runs exactly WIDTH iterations of EVAL + MUL + SQR, including the top bit.
  - When the exponent bit is 0, the MUL result is computed and discarded.
  - L = WIDTH + 2*WIDTH*WIDTH (528 for WIDTH=16), independent of key value.
  - Invalid-request timing is unchanged.
- RSA_CONST_TIME_EN undefined: early-exit schedule as in Operation/Timing.

## Test plan
- Encrypt, default build, WIDTH=16: E_D=10, msg_in=65, key_e=17, modulus_n=3233, start at edge k -> result=2790, done at edge k+101, err=0.
- Decrypt: E_D=01, msg_in=2790, key_d=2753, modulus_n=3233 -> result=65, err=0. With RSA_CONST_TIME_EN defined, encrypt and decrypt both give done at edge k+528.
- Invalid mode and operands:
  - E_D=11 with start -> done at edge k+1, err=1, result=0.
  - msg_in=3233 with modulus_n=3233 -> same response.
  - Next valid start clears err.
- Handshake: start pulses at edges k+5 and k+50 during a busy encrypt -> both ignored, single done at k+101. E_D toggled mid-run -> result still 2790.
- Reset mid-operation: rst_n=0 for 1 cycle at edge k+40 -> busy/done/err/result all 0 at edge k+40, no done afterwards. A fresh start then completes correctly.
- Edge values: key_e=0 -> result=1 at edge k+1. msg_in=0, key_e=17 -> result=0. modulus_n=65535, msg_in=65534, key_e=3 -> result=65534.

Source files
------------

// File: rtl/rsa_modexp_engine.sv
// Bit-serial square-and-multiply RSA engine: result = msg^key mod n, using an MSB-first interleaved modular multiplier.
// Optional RSA_CONST_TIME_EN: fixed WIDTH-iteration schedule independent of the key value.
module rsa_modexp_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       E_D,
    input  logic             start,
    input  logic [WIDTH-1:0] msg_in,
    input  logic [WIDTH-1:0] key_e,
    input  logic [WIDTH-1:0] key_d,
    input  logic [WIDTH-1:0] modulus_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_TOP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_EVAL, S_MUL, S_SQR, S_FIN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_base, r_exp, r_acc, r_n, r_p, r_result;
    logic [CW-1:0]    r_bit;
    logic             r_err;
`ifdef RSA_CONST_TIME_EN
    logic [CW-1:0]    r_iter;
`endif

    logic             w_req_valid, w_mul_last;
    logic [WIDTH-1:0] w_key, w_a, w_p_next;

    function automatic logic [WIDTH+1:0] mod_reduce(input logic [WIDTH+1:0] x,
                                                    input logic [WIDTH-1:0] n);
        return (x >= {2'b00, n}) ? (x - {2'b00, n}) : x;
    endfunction

    // One interleaved step: p = 2p mod n, then p = p + a mod n when the multiplier bit is set.
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             b_bit,
                                                  input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] t;
        t = mod_reduce({1'b0, p, 1'b0}, n);
        if (b_bit) t = mod_reduce(t + {2'b00, a}, n);
        return t[WIDTH-1:0];
    endfunction

    assign w_req_valid = ((E_D == 2'b10) || (E_D == 2'b01)) &&
                         (modulus_n >= WIDTH'(2)) && (msg_in < modulus_n);
    assign w_key       = (E_D == 2'b01) ? key_d : key_e;
    assign w_mul_last  = (r_bit == '0);
    assign w_a         = (r_state == S_MUL) ? r_acc : r_base;
    assign w_p_next    = mod_step(r_p, w_a, r_base[r_bit], r_n);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_EVAL;
`ifdef RSA_CONST_TIME_EN
            S_EVAL: w_next = r_err ? S_FIN : S_MUL;
            S_MUL:  if (w_mul_last) w_next = S_SQR;
            S_SQR:  if (w_mul_last) w_next = (r_iter == BIT_TOP) ? S_FIN : S_EVAL;
`else
            S_EVAL: begin
                if (r_err || r_exp == '0) w_next = S_FIN;
                else if (r_exp[0])        w_next = S_MUL;
                else                      w_next = S_SQR;
            end
            S_MUL:  if (w_mul_last) w_next = ((r_exp >> 1) == '0) ? S_FIN : S_SQR;
            S_SQR:  if (w_mul_last) w_next = S_EVAL;
`endif
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_FIN);
    end

    assign err    = r_err;
    assign result = r_result;

    // Invalid requests are funnelled through EVAL with a zero exponent so they reach FIN one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_exp    <= '0;
            r_acc    <= '0;
            r_n      <= '0;
            r_p      <= '0;
            r_bit    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
`ifdef RSA_CONST_TIME_EN
            r_iter   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_err  <= !w_req_valid;
                    r_base <= msg_in;
                    r_exp  <= w_req_valid ? w_key : '0;
                    r_acc  <= WIDTH'(1);
                    r_n    <= modulus_n;
                    r_p    <= '0;
                    r_bit  <= BIT_TOP;
`ifdef RSA_CONST_TIME_EN
                    r_iter <= '0;
`endif
                end
                S_EVAL: begin
                    r_p   <= '0;
                    r_bit <= BIT_TOP;
                    if (w_next == S_FIN) r_result <= r_err ? '0 : r_acc;
                end
                S_MUL: begin
                    r_p   <= w_p_next;
                    r_bit <= r_bit - CW'(1);
                    if (w_mul_last) begin
                        r_p   <= '0;
                        r_bit <= BIT_TOP;
`ifdef RSA_CONST_TIME_EN
                        if (r_exp[0]) r_acc <= w_p_next;
`else
                        r_acc <= w_p_next;
                        if (w_next == S_FIN) begin
                            r_exp    <= r_exp >> 1;
                            r_result <= w_p_next;
                        end
`endif
                    end
                end
                S_SQR: begin
                    r_p   <= w_p_next;
                    r_bit <= r_bit - CW'(1);
                    if (w_mul_last) begin
                        r_p    <= '0;
                        r_bit  <= BIT_TOP;
                        r_base <= w_p_next;
                        r_exp  <= r_exp >> 1;
`ifdef RSA_CONST_TIME_EN
                        r_iter <= r_iter + CW'(1);
                        if (w_next == S_FIN) r_result <= r_acc;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine: directed RSA vectors plus randomized requests against an arithmetic model.
module tb_rsa_modexp_engine;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   E_D = 2'b00;
    logic [W-1:0] msg_in = '0, key_e = '0, key_d = '0, modulus_n = '0;
    logic         busy, done, err;
    logic [W-1:0] result;

    rsa_modexp_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .E_D(E_D), .start(start),
        .msg_in(msg_in), .key_e(key_e), .key_d(key_d), .modulus_n(modulus_n),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint modexp(input longint m, input longint k, input longint n);
        longint r = 1, b = m % n, e = k;
        while (e != 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r % n;
    endfunction

    function automatic int latency(input int key, input bit valid);
        int bl = 0, pc = 0;
        if (!valid) return 1;
`ifdef RSA_CONST_TIME_EN
        return W + 2 * W * W;
`else
        for (int i = 0; i < W; i++) if (key[i]) begin bl = i + 1; pc++; end
        if (key == 0) return 1;
        return bl + W * (pc + bl - 1);
`endif
    endfunction

    // Expected behaviour of the request in flight and the values held afterwards.
    bit           active = 1'b0;
    int           k_acc = 0, lat = 0;
    logic [W-1:0] exp_res = '0, last_res = '0;
    logic         exp_err = 1'b0, last_err = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (active && cyc >= k_acc) begin
            check("busy", busy, 32'(cyc <= k_acc + lat));
            check("done", done, 32'(cyc == k_acc + lat));
            if (cyc == k_acc + lat) begin
                check("result", result, exp_res);
                check("err", err, exp_err);
                last_res = exp_res;
                last_err = exp_err;
            end
            if (cyc > k_acc + lat) active = 1'b0;
        end else if (!active) begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("held_result", result, last_res);
            check("held_err", err, last_err);
        end
    end

    task automatic request(input logic [1:0] ed, input logic [W-1:0] m, input logic [W-1:0] ke,
                           input logic [W-1:0] kd, input logic [W-1:0] n,
                           input bit pulses, input bit toggle);
        bit           valid;
        logic [W-1:0] key;
        @(negedge clk);
        valid = ((ed == 2'b10) || (ed == 2'b01)) && (n >= 2) && (m < n);
        key   = (ed == 2'b01) ? kd : ke;
        E_D = ed; msg_in = m; key_e = ke; key_d = kd; modulus_n = n; start = 1'b1;
        k_acc   = cyc + 1;
        lat     = latency(int'(key), valid);
        exp_res = valid ? W'(modexp(longint'(m), longint'(key), longint'(n))) : '0;
        exp_err = !valid;
        active  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        msg_in = W'($urandom); key_e = W'($urandom); key_d = W'($urandom);
        if (toggle) E_D = ~ed;
        if (pulses && lat > 50) begin
            while (cyc != k_acc + 4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (cyc != k_acc + 49) @(negedge clk);
            start = 1'b1; E_D = 2'b11;
            @(negedge clk);
            start = 1'b0;
        end
        while (active) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        check("pin_enc_model", 32'(modexp(65, 17, 3233)), 2790);
        check("pin_dec_model", 32'(modexp(2790, 2753, 3233)), 65);
`ifdef RSA_CONST_TIME_EN
        check("pin_lat_model", 32'(latency(17, 1'b1)), 528);
`else
        check("pin_lat_model", 32'(latency(17, 1'b1)), 101);
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        request(2'b10, 16'd65,   16'd17,   16'd2753, 16'd3233, 1'b0, 1'b0);
        check("enc_literal", result, 2790);
        request(2'b01, 16'd2790, 16'd17,   16'd2753, 16'd3233, 1'b0, 1'b0);
        check("dec_literal", result, 65);
        request(2'b11, 16'd65,   16'd17,   16'd2753, 16'd3233, 1'b0, 1'b0);
        check("inv_mode_err", err, 1);
        request(2'b10, 16'd3233, 16'd17,   16'd2753, 16'd3233, 1'b0, 1'b0);
        check("inv_msg_err", err, 1);
        request(2'b00, 16'd5,    16'd3,    16'd3,    16'd7,    1'b0, 1'b0);
        request(2'b10, 16'd0,    16'd3,    16'd3,    16'd1,    1'b0, 1'b0);
        request(2'b10, 16'd65,   16'd17,   16'd2753, 16'd3233, 1'b1, 1'b1);
        check("err_cleared", err, 0);
        request(2'b10, 16'd1234, 16'd0,    16'd9,    16'd3233, 1'b0, 1'b0);
        check("key0_result", result, 1);
        request(2'b10, 16'd0,    16'd17,   16'd9,    16'd3233, 1'b0, 1'b0);
        request(2'b10, 16'd65534, 16'd3,   16'd9,    16'd65535, 1'b0, 1'b0);
        check("edge_n_max", result, 65534);

        // Reset in the middle of an encrypt: no completion may follow.
        fork
            request(2'b10, 16'd65, 16'd17, 16'd2753, 16'd3233, 1'b0, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                while (cyc != k_acc + 39) @(negedge clk);
                rst_n = 1'b0;
                active = 1'b0;
                last_res = '0;
                last_err = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (150) @(negedge clk);
        request(2'b01, 16'd2790, 16'd17, 16'd2753, 16'd3233, 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            int           r;
            logic [1:0]   ed;
            logic [W-1:0] n, m;
            r  = $urandom_range(0, 11);
            n  = W'($urandom_range(2, 65535));
            m  = W'($urandom_range(0, int'(n) - 1));
            ed = r[0] ? 2'b01 : 2'b10;
            if (r == 0) ed = 2'b00;
            if (r == 1) ed = 2'b11;
            if (r == 2) m = W'($urandom_range(int'(n), 65535));
            if (r == 3) n = W'($urandom_range(0, 1));
            request(ed, m, W'($urandom), W'($urandom), n, 1'b0, r == 4);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
